// File: rtl/rv32_bus_arb_pkg.sv
// Shared types for the RV32 instruction/data bus arbiter and its watchdog.
package rv32_bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_INSTR,
        BUSY_DATA
    } rv32_bus_arb_state_t;

    typedef enum logic {
        GRANT_INSTR,
        GRANT_DATA
    } rv32_bus_grant_t;

    // A disabled watchdog (timeout 0) still gets a 1-bit counter so the vector is never empty.
    function automatic int unsigned wd_cnt_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/rv32_bus_watchdog.sv
// Saturating wait counter for a granted bus transfer; flags the final allowed wait cycle.
module rv32_bus_watchdog
    import rv32_bus_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int unsigned CntW = wd_cnt_width(TIMEOUT);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count && (cnt_q != {CntW{1'b1}})) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/rv32_bus_arbiter.sv
// Arbitrates one memory bus between fetch (instr) and load/store (data) ports with a watchdog.
// Define RV32_BUS_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise data wins ties.
module rv32_bus_arbiter
    import rv32_bus_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_read_in,
    input  logic [31:0] instr_address_in,
    output logic        instr_ready_out,
    output logic        instr_fault_out,
    output logic [31:0] instr_read_value_out,
    input  logic        data_read_in,
    input  logic        data_write_in,
    input  logic [31:0] data_address_in,
    input  logic [3:0]  data_write_mask_in,
    input  logic [31:0] data_write_value_in,
    output logic        data_ready_out,
    output logic        data_fault_out,
    output logic [31:0] data_read_value_out,
    output logic        bus_read_out,
    output logic        bus_write_out,
    output logic [31:0] bus_address_out,
    output logic [3:0]  bus_write_mask_out,
    output logic [31:0] bus_write_value_out,
    input  logic [31:0] bus_read_value_in,
    input  logic        bus_ready_in
);

    rv32_bus_arb_state_t state_q, state_d;
    rv32_bus_grant_t     grant;
    rv32_bus_grant_t     tie_winner;
    logic                grant_valid;
    logic                done;
    logic                abort;
    logic                instr_req;
    logic                data_req;
    logic                wd_clear;
    logic                wd_count;
    logic                wd_expired;

    assign instr_req = instr_read_in;
    assign data_req  = data_read_in | data_write_in;

`ifdef RV32_BUS_ARB_ROUND_ROBIN_EN
    rv32_bus_grant_t last_grant_q, last_grant_d;

    always_comb begin
        last_grant_d = last_grant_q;
        if (done) begin
            last_grant_d = grant;
        end
        tie_winner = (last_grant_q == GRANT_INSTR) ? GRANT_DATA : GRANT_INSTR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= GRANT_INSTR;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    assign tie_winner = GRANT_DATA;
`endif

    always_comb begin
        state_d     = state_q;
        grant       = GRANT_INSTR;
        grant_valid = 1'b0;
        done        = 1'b0;
        abort       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (instr_req || data_req) begin
                    grant_valid = 1'b1;
                    if (instr_req && data_req) begin
                        grant = tie_winner;
                    end else begin
                        grant = data_req ? GRANT_DATA : GRANT_INSTR;
                    end
                    if (bus_ready_in) begin
                        done = 1'b1;
                    end else begin
                        state_d = (grant == GRANT_DATA) ? BUSY_DATA : BUSY_INSTR;
                    end
                end
            end
            BUSY_INSTR, BUSY_DATA: begin
                grant_valid = 1'b1;
                grant       = (state_q == BUSY_DATA) ? GRANT_DATA : GRANT_INSTR;
                // A ready arriving on the expiry cycle completes normally.
                if (bus_ready_in) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else if (wd_expired) begin
                    done    = 1'b1;
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign wd_clear = (state_q == IDLE) || done;
    assign wd_count = (state_q != IDLE);

    rv32_bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .count   (wd_count),
        .expired (wd_expired)
    );

    always_comb begin
        bus_read_out        = 1'b0;
        bus_write_out       = 1'b0;
        bus_address_out     = '0;
        bus_write_mask_out  = '0;
        bus_write_value_out = '0;
        instr_ready_out     = 1'b0;
        instr_fault_out     = 1'b0;
        data_ready_out      = 1'b0;
        data_fault_out      = 1'b0;
        if (grant_valid) begin
            if (grant == GRANT_DATA) begin
                bus_address_out     = data_address_in;
                bus_write_value_out = data_write_value_in;
                bus_read_out        = data_read_in & ~abort;
                bus_write_out       = data_write_in & ~abort;
                data_ready_out      = done;
                data_fault_out      = abort;
            end else begin
                bus_address_out = instr_address_in;
                bus_read_out    = instr_read_in & ~abort;
                instr_ready_out = done;
                instr_fault_out = abort;
            end
        end
        if (bus_write_out) begin
            bus_write_mask_out = data_write_mask_in;
        end
        if (reset) begin
            bus_read_out       = 1'b0;
            bus_write_out      = 1'b0;
            bus_write_mask_out = '0;
            instr_ready_out    = 1'b0;
            instr_fault_out    = 1'b0;
            data_ready_out     = 1'b0;
            data_fault_out     = 1'b0;
        end
        instr_read_value_out = instr_fault_out ? '0 : bus_read_value_in;
        data_read_value_out  = data_fault_out ? '0 : bus_read_value_in;
    end

endmodule

// File: tb/tb_rv32_bus_arbiter.sv
// Scoreboard bench for rv32_bus_arbiter: a TIMEOUT=4 instance plus a watchdog-disabled instance.
module tb_rv32_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_read_in;
    logic [31:0] instr_address_in;
    logic        data_read_in;
    logic        data_write_in;
    logic [31:0] data_address_in;
    logic [3:0]  data_write_mask_in;
    logic [31:0] data_write_value_in;
    logic [31:0] bus_read_value_in;
    logic        bus_ready_in;

    logic        instr_ready_out, instr_fault_out, data_ready_out, data_fault_out;
    logic [31:0] instr_read_value_out, data_read_value_out;
    logic        bus_read_out, bus_write_out;
    logic [31:0] bus_address_out, bus_write_value_out;
    logic [3:0]  bus_write_mask_out;

    logic        n_instr_ready_out, n_instr_fault_out, n_data_ready_out, n_data_fault_out;
    logic [31:0] n_instr_read_value_out, n_data_read_value_out;
    logic        n_bus_read_out, n_bus_write_out;
    logic [31:0] n_bus_address_out, n_bus_write_value_out;
    logic [3:0]  n_bus_write_mask_out;

    typedef struct {
        logic        is_data;
        logic        fault;
        logic [31:0] rdata;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int        n_checks = 0;
    int        n_errors = 0;
    logic      mon_en;
    logic      lg;  // model of last_grant: 0 instr, 1 data

    always #5 clk = ~clk;

    rv32_bus_arbiter #(
        .TIMEOUT (4)
    ) u_dut (
        .clk                  (clk),
        .reset                (reset),
        .instr_read_in        (instr_read_in),
        .instr_address_in     (instr_address_in),
        .instr_ready_out      (instr_ready_out),
        .instr_fault_out      (instr_fault_out),
        .instr_read_value_out (instr_read_value_out),
        .data_read_in         (data_read_in),
        .data_write_in        (data_write_in),
        .data_address_in      (data_address_in),
        .data_write_mask_in   (data_write_mask_in),
        .data_write_value_in  (data_write_value_in),
        .data_ready_out       (data_ready_out),
        .data_fault_out       (data_fault_out),
        .data_read_value_out  (data_read_value_out),
        .bus_read_out         (bus_read_out),
        .bus_write_out        (bus_write_out),
        .bus_address_out      (bus_address_out),
        .bus_write_mask_out   (bus_write_mask_out),
        .bus_write_value_out  (bus_write_value_out),
        .bus_read_value_in    (bus_read_value_in),
        .bus_ready_in         (bus_ready_in)
    );

    rv32_bus_arbiter #(
        .TIMEOUT (0)
    ) u_dut_nowd (
        .clk                  (clk),
        .reset                (reset),
        .instr_read_in        (instr_read_in),
        .instr_address_in     (instr_address_in),
        .instr_ready_out      (n_instr_ready_out),
        .instr_fault_out      (n_instr_fault_out),
        .instr_read_value_out (n_instr_read_value_out),
        .data_read_in         (data_read_in),
        .data_write_in        (data_write_in),
        .data_address_in      (data_address_in),
        .data_write_mask_in   (data_write_mask_in),
        .data_write_value_in  (data_write_value_in),
        .data_ready_out       (n_data_ready_out),
        .data_fault_out       (n_data_fault_out),
        .data_read_value_out  (n_data_read_value_out),
        .bus_read_out         (n_bus_read_out),
        .bus_write_out        (n_bus_write_out),
        .bus_address_out      (n_bus_address_out),
        .bus_write_mask_out   (n_bus_write_mask_out),
        .bus_write_value_out  (n_bus_write_value_out),
        .bus_read_value_in    (bus_read_value_in),
        .bus_ready_in         (bus_ready_in)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input logic is_data, input logic fault, input logic [31:0] rdata);
        sb_entry_t e;
        e.is_data = is_data;
        e.fault   = fault;
        e.rdata   = rdata;
        sb_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Every completion of the TIMEOUT=4 instance is matched against the scoreboard.
    always @(negedge clk) begin
        sb_entry_t e;
        if (mon_en && !reset && (instr_ready_out || data_ready_out)) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_unexpected_ready", {31'b0, instr_ready_out | data_ready_out}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq("ready_data_port", {31'b0, data_ready_out}, {31'b0, e.is_data});
                check_eq("ready_instr_port", {31'b0, instr_ready_out}, {31'b0, !e.is_data});
                if (e.is_data) begin
                    check_eq("data_fault", {31'b0, data_fault_out}, {31'b0, e.fault});
                    check_eq("data_rdata", data_read_value_out, e.rdata);
                    check_eq("instr_fault_idle", {31'b0, instr_fault_out}, 32'd0);
                end else begin
                    check_eq("instr_fault", {31'b0, instr_fault_out}, {31'b0, e.fault});
                    check_eq("instr_rdata", instr_read_value_out, e.rdata);
                    check_eq("data_fault_idle", {31'b0, data_fault_out}, 32'd0);
                end
            end
        end
    end

    task automatic run_tie(input string tag);
        logic first_data;
`ifdef RV32_BUS_ARB_ROUND_ROBIN_EN
        first_data = (lg == 1'b0);
`else
        first_data = 1'b1;
`endif
        next_cycle();
        instr_read_in    = 1'b1;
        instr_address_in = 32'h40;
        data_read_in     = 1'b1;
        data_address_in  = 32'h2000;
        bus_ready_in     = 1'b0;
        sb_push(first_data, 1'b0, 32'hD0D0_0001);
        sb_push(!first_data, 1'b0, 32'hF0F0_0002);
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) begin
                bus_ready_in      = 1'b1;
                bus_read_value_in = 32'hD0D0_0001;
            end
            sample();
            check_eq({tag, "_first_addr"}, bus_address_out, first_data ? 32'h2000 : 32'h40);
            check_eq({tag, "_first_read"}, {31'b0, bus_read_out}, 32'd1);
            next_cycle();
        end
        if (first_data) data_read_in = 1'b0;
        else instr_read_in = 1'b0;
        bus_read_value_in = 32'hF0F0_0002;
        bus_ready_in      = 1'b1;
        sample();
        check_eq({tag, "_second_addr"}, bus_address_out, first_data ? 32'h40 : 32'h2000);
        next_cycle();
        instr_read_in = 1'b0;
        data_read_in  = 1'b0;
        bus_ready_in  = 1'b0;
        sample();
        check_eq({tag, "_idle_read"}, {31'b0, bus_read_out}, 32'd0);
        lg = !first_data;
    endtask

    initial begin
        int bad;
        reset               = 1'b1;
        mon_en              = 1'b1;
        lg                  = 1'b0;
        instr_read_in       = 1'b1;
        instr_address_in    = 32'h0;
        data_read_in        = 1'b0;
        data_write_in       = 1'b0;
        data_address_in     = 32'h0;
        data_write_mask_in  = 4'h0;
        data_write_value_in = 32'h0;
        bus_read_value_in   = 32'h0;
        bus_ready_in        = 1'b1;
        repeat (2) @(posedge clk);
        sample();
        check_eq("rst_instr_ready", {31'b0, instr_ready_out}, 32'd0);
        check_eq("rst_bus_read", {31'b0, bus_read_out}, 32'd0);
        check_eq("rst_nowd_bus_read", {31'b0, n_bus_read_out}, 32'd0);

        // Zero-wait fetch.
        next_cycle();
        reset             = 1'b0;
        instr_address_in  = 32'h100;
        bus_read_value_in = 32'h1111_1111;
        sb_push(1'b0, 1'b0, 32'h1111_1111);
        sample();
        check_eq("t1_addr", bus_address_out, 32'h100);
        check_eq("t1_read", {31'b0, bus_read_out}, 32'd1);
        check_eq("t1_mask", {28'b0, bus_write_mask_out}, 32'd0);
        next_cycle();
        instr_read_in = 1'b0;
        bus_ready_in  = 1'b0;
        sample();
        check_eq("t1_idle", {30'b0, bus_read_out, bus_write_out}, 32'd0);
        lg = 1'b0;

        run_tie("t2a");

        // Store with 3 wait cycles; fetch requests are ignored while busy.
        next_cycle();
        data_write_in       = 1'b1;
        data_address_in     = 32'h8;
        data_write_mask_in  = 4'b0100;
        data_write_value_in = 32'hAABB_CCDD;
        bus_read_value_in   = 32'h0;
        sb_push(1'b1, 1'b0, 32'h0);
        for (int c = 1; c <= 4; c++) begin
            if (c >= 2) begin
                instr_read_in    = 1'b1;
                instr_address_in = 32'h80;
            end
            if (c == 4) bus_ready_in = 1'b1;
            sample();
            check_eq("t3_write", {31'b0, bus_write_out}, 32'd1);
            check_eq("t3_read", {31'b0, bus_read_out}, 32'd0);
            check_eq("t3_mask", {28'b0, bus_write_mask_out}, 32'h4);
            check_eq("t3_addr", bus_address_out, 32'h8);
            check_eq("t3_wdata", bus_write_value_out, 32'hAABB_CCDD);
            next_cycle();
        end
        data_write_in = 1'b0;
        instr_read_in = 1'b0;
        bus_ready_in  = 1'b0;
        sample();
        check_eq("t3_idle_write", {31'b0, bus_write_out}, 32'd0);
        check_eq("t3_idle_mask", {28'b0, bus_write_mask_out}, 32'd0);
        lg = 1'b1;

        run_tie("t2b");

        // Watchdog abort after TIMEOUT waits.
        next_cycle();
        data_read_in      = 1'b1;
        data_address_in   = 32'h3000;
        bus_read_value_in = 32'hDEAD_BEEF;
        sb_push(1'b1, 1'b1, 32'h0);
        for (int c = 1; c <= 5; c++) begin
            sample();
            check_eq("t4_read_strobe", {31'b0, bus_read_out}, (c < 5) ? 32'd1 : 32'd0);
            next_cycle();
        end
        data_read_in = 1'b0;
        sample();
        check_eq("t4_idle", {31'b0, bus_read_out}, 32'd0);
        lg = 1'b1;

        // Ready on the expiry cycle wins over the fault.
        next_cycle();
        data_read_in      = 1'b1;
        data_address_in   = 32'h3004;
        bus_read_value_in = 32'h1234_5678;
        sb_push(1'b1, 1'b0, 32'h1234_5678);
        for (int c = 1; c <= 5; c++) begin
            if (c == 5) bus_ready_in = 1'b1;
            sample();
            check_eq("t4b_read_strobe", {31'b0, bus_read_out}, 32'd1);
            next_cycle();
        end
        data_read_in = 1'b0;
        bus_ready_in = 1'b0;
        sample();
        check_eq("t4b_idle", {31'b0, bus_read_out}, 32'd0);

        // Reset in the middle of a data transfer.
        next_cycle();
        data_read_in    = 1'b1;
        data_address_in = 32'h4000;
        sample();
        next_cycle();
        sample();
        check_eq("t5_busy_read", {31'b0, bus_read_out}, 32'd1);
        next_cycle();
        reset = 1'b1;
        sample();
        check_eq("t5_rst_read", {31'b0, bus_read_out}, 32'd0);
        check_eq("t5_rst_readys", {30'b0, instr_ready_out, data_ready_out}, 32'd0);
        check_eq("t5_rst_faults", {30'b0, instr_fault_out, data_fault_out}, 32'd0);
        next_cycle();
        reset             = 1'b0;
        data_read_in      = 1'b0;
        instr_read_in     = 1'b1;
        instr_address_in  = 32'h44;
        bus_ready_in      = 1'b1;
        bus_read_value_in = 32'h4444_4444;
        sb_push(1'b0, 1'b0, 32'h4444_4444);
        sample();
        check_eq("t5_fetch_addr", bus_address_out, 32'h44);
        check_eq("t5_fetch_read", {31'b0, bus_read_out}, 32'd1);
        next_cycle();
        instr_read_in = 1'b0;
        bus_ready_in  = 1'b0;
        sample();
        check_eq("t5_idle", {31'b0, bus_read_out}, 32'd0);
        lg = 1'b0;

        // Watchdog disabled: a 1000-cycle wait never faults.
        next_cycle();
        mon_en            = 1'b0;
        data_read_in      = 1'b1;
        data_address_in   = 32'h5000;
        bus_read_value_in = 32'hCAFE_F00D;
        bad               = 0;
        repeat (1000) begin
            sample();
            if (n_data_ready_out || n_data_fault_out || !n_bus_read_out) bad++;
            next_cycle();
        end
        check_eq("t6_wait_clean", bad, 32'd0);
        bus_ready_in = 1'b1;
        sample();
        check_eq("t6_ready", {31'b0, n_data_ready_out}, 32'd1);
        check_eq("t6_fault", {31'b0, n_data_fault_out}, 32'd0);
        check_eq("t6_rdata", n_data_read_value_out, 32'hCAFE_F00D);
        next_cycle();
        data_read_in = 1'b0;
        bus_ready_in = 1'b0;
        reset        = 1'b1;
        sample();
        next_cycle();
        reset  = 1'b0;
        mon_en = 1'b1;
        sample();
        check_eq("sb_empty", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
